// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multicycle control FSM: state and ALU
// encodings, one-hot decoder bit positions, datapath select codes.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    // Bit positions in the decoder's one-hot code; bits 31 and up are reserved.
    localparam int B_ADD   = 0;
    localparam int B_ADDU  = 1;
    localparam int B_SUB   = 2;
    localparam int B_SUBU  = 3;
    localparam int B_AND   = 4;
    localparam int B_OR    = 5;
    localparam int B_XOR   = 6;
    localparam int B_NOR   = 7;
    localparam int B_SLT   = 8;
    localparam int B_SLTU  = 9;
    localparam int B_SLL   = 10;
    localparam int B_SRL   = 11;
    localparam int B_SRA   = 12;
    localparam int B_SLLV  = 13;
    localparam int B_SRLV  = 14;
    localparam int B_SRAV  = 15;
    localparam int B_JR    = 16;
    localparam int B_ADDI  = 17;
    localparam int B_ADDIU = 18;
    localparam int B_ANDI  = 19;
    localparam int B_ORI   = 20;
    localparam int B_XORI  = 21;
    localparam int B_LUI   = 22;
    localparam int B_LW    = 23;
    localparam int B_SW    = 24;
    localparam int B_BEQ   = 25;
    localparam int B_BNE   = 26;
    localparam int B_SLTI  = 27;
    localparam int B_SLTIU = 28;
    localparam int B_J     = 29;
    localparam int B_JAL   = 30;
    localparam int LEGAL_W = 31;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_t;

    localparam logic [1:0] DST_RD    = 2'd0;
    localparam logic [1:0] DST_RT    = 2'd1;
    localparam logic [1:0] DST_RA    = 2'd2;

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    // Address arithmetic for loads/stores and jumps uses the adder as well.
    function automatic alu_op_t alu_op_of(input logic [LEGAL_W-1:0] c);
        alu_op_t op;
        op = ALU_ADD;
        if (c[B_ADD] | c[B_ADDU] | c[B_ADDI] | c[B_ADDIU] | c[B_LW] | c[B_SW]) op = ALU_ADD;
        if (c[B_SUB] | c[B_SUBU] | c[B_BEQ] | c[B_BNE])   op = ALU_SUB;
        if (c[B_AND] | c[B_ANDI])                          op = ALU_AND;
        if (c[B_OR]  | c[B_ORI])                           op = ALU_OR;
        if (c[B_XOR] | c[B_XORI])                          op = ALU_XOR;
        if (c[B_NOR])                                      op = ALU_NOR;
        if (c[B_SLT] | c[B_SLTI])                          op = ALU_SLT;
        if (c[B_SLTU] | c[B_SLTIU])                        op = ALU_SLTU;
        if (c[B_SLL] | c[B_SLLV])                          op = ALU_SLL;
        if (c[B_SRL] | c[B_SRLV])                          op = ALU_SRL;
        if (c[B_SRA] | c[B_SRAV])                          op = ALU_SRA;
        if (c[B_LUI])                                      op = ALU_LUI;
        return op;
    endfunction

endpackage

// File: rtl/ctrl_code_check.sv
// Combinational legality check and instruction-class extraction for a
// one-hot decoder code (exactly one of bits 30:0 set, reserved bits clear).
module ctrl_code_check
    import cpu_ctrl_pkg::*;
#(
    parameter int CODE_W = 54
) (
    input  logic [CODE_W-1:0] code,
    output logic              legal,
    output logic              is_r,
    output logic              is_imm,
    output logic              is_ld,
    output logic              is_st,
    output logic              is_br,
    output logic              is_jmp
);

    logic [5:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < LEGAL_W; i++) begin
            ones = ones + 6'(code[i]);
        end
        legal = (ones == 6'd1) && (code[CODE_W-1:LEGAL_W] == '0);
    end

    assign is_r   = |code[B_SRAV:B_ADD];
    assign is_imm = code[B_ADDI] | code[B_ADDIU] | code[B_ANDI] | code[B_ORI]
                  | code[B_XORI] | code[B_LUI]   | code[B_SLTI] | code[B_SLTIU];
    assign is_ld  = code[B_LW];
    assign is_st  = code[B_SW];
    assign is_br  = code[B_BEQ] | code[B_BNE];
    assign is_jmp = code[B_JR] | code[B_J] | code[B_JAL];

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM sequencing fetch/decode/exec/mem/write-back and counting retired instructions.
// Build option ILLEGAL_TRAP_EN: an illegal code halts in TRAP; otherwise it retires as a NOP.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CODE_W = 54,
    parameter int RET_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code,
    input  logic              zero,
    input  logic              imem_ack,
    input  logic              dmem_ack,
    output logic              imem_req,
    output logic              ir_we,
    output logic              dec_ena,
    output logic [3:0]        alu_op,
    output logic              alu_b_sel,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              reg_we,
    output logic [1:0]        reg_dst_sel,
    output logic [1:0]        wb_sel,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              halted,
    output logic [RET_W-1:0]  retired,
    output logic [2:0]        state
);

    state_t            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_clean, chk_code;
    logic              legal, is_r, is_imm, is_ld, is_st, is_br, is_jmp;
    logic              retire, trap_entry;

    // Undriven (x/z) decoder bits read as 0, so a floating decoder looks illegal.
    always_comb begin
        code_clean = '0;
        for (int i = 0; i < CODE_W; i++) begin
            code_clean[i] = (code[i] === 1'b1);
        end
    end

    // Legality is judged on the live code in DECODE; later states use the latched copy.
    assign chk_code = (state_q == DECODE) ? code_clean : code_q;

    ctrl_code_check #(.CODE_W(CODE_W)) u_check (
        .code   (chk_code),
        .legal  (legal),
        .is_r   (is_r),
        .is_imm (is_imm),
        .is_ld  (is_ld),
        .is_st  (is_st),
        .is_br  (is_br),
        .is_jmp (is_jmp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            code_q  <= '0;
            retired <= '0;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) code_q  <= code_clean;
            if (retire)            retired <= retired + RET_W'(1);
            if (trap_entry)        halted  <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        state_d     = state_q;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        dec_ena     = 1'b0;
        alu_op      = ALU_ADD;
        alu_b_sel   = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_we      = 1'b0;
        reg_dst_sel = DST_RD;
        wb_sel      = WB_ALU;
        pc_we       = 1'b0;
        pc_sel      = PC_PLUS4;
        retire      = 1'b0;
        trap_entry  = 1'b0;

        // Strobes are held low while reset is asserted, dropping any request at once.
        if (rst_n) begin
            unique case (state_q)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        pc_sel  = PC_PLUS4;
                        state_d = DECODE;
                    end
                end

                DECODE: begin
                    dec_ena = 1'b1;
                    if (legal) begin
                        state_d = EXEC;
                    end else begin
`ifdef ILLEGAL_TRAP_EN
                        state_d    = TRAP;
                        trap_entry = 1'b1;
`else
                        state_d    = FETCH;
                        retire     = 1'b1;
`endif
                    end
                end

                EXEC: begin
                    alu_op    = alu_op_of(code_q[LEGAL_W-1:0]);
                    alu_b_sel = is_imm | is_ld | is_st;
                    if (is_br) begin
                        pc_we   = (zero == code_q[B_BEQ]);
                        pc_sel  = PC_BRANCH;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else if (is_jmp && !code_q[B_JAL]) begin
                        pc_we   = 1'b1;
                        pc_sel  = code_q[B_JR] ? PC_REG : PC_JUMP;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else if (is_ld || is_st) begin
                        state_d = MEM;
                    end else if (is_r || is_imm || code_q[B_JAL]) begin
                        state_d = WB;
                    end else begin
                        state_d = FETCH;
                    end
                end

                MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_st;
                    if (dmem_ack) begin
                        if (is_st) begin
                            retire  = 1'b1;
                            state_d = FETCH;
                        end else begin
                            state_d = WB;
                        end
                    end
                end

                WB: begin
                    reg_we  = 1'b1;
                    retire  = 1'b1;
                    state_d = FETCH;
                    if (code_q[B_JAL]) begin
                        reg_dst_sel = DST_RA;
                        wb_sel      = WB_PC4;
                        pc_we       = 1'b1;
                        pc_sel      = PC_JUMP;
                    end else if (is_ld) begin
                        reg_dst_sel = DST_RT;
                        wb_sel      = WB_MEM;
                    end else if (is_imm) begin
                        reg_dst_sel = DST_RT;
                    end
                end

                TRAP: begin
                    state_d = TRAP;
                end

                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle comparison against a phase-list reference model.
module tb_multicycle_ctrl;
    import cpu_ctrl_pkg::*;

    localparam int CODE_W = 54;
    localparam int RET_W  = 32;

    typedef enum {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_JR, K_JAL, K_BAD} kind_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CODE_W-1:0] code;
    logic              zero, imem_ack, dmem_ack;
    logic              imem_req, ir_we, dec_ena, alu_b_sel, dmem_req, dmem_we, reg_we, pc_we, halted;
    logic [3:0]        alu_op;
    logic [1:0]        reg_dst_sel, wb_sel, pc_sel;
    logic [RET_W-1:0]  retired;
    logic [2:0]        state;

    int               checks = 0;
    int               failures = 0;
    logic [RET_W-1:0] exp_retired = '0;
    logic             exp_halted = 1'b0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CODE_W(CODE_W), .RET_W(RET_W)) dut (
        .clk(clk), .rst_n(rst_n), .code(code), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we),
        .dec_ena(dec_ena), .alu_op(alu_op), .alu_b_sel(alu_b_sel), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .reg_we(reg_we), .reg_dst_sel(reg_dst_sel), .wb_sel(wb_sel),
        .pc_we(pc_we), .pc_sel(pc_sel), .halted(halted), .retired(retired), .state(state)
    );

    function automatic kind_t kind_of(input int b);
        if (b <= 15) return K_R;
        if (b == 16) return K_JR;
        if (b == 23) return K_LW;
        if (b == 24) return K_SW;
        if (b == 25 || b == 26) return K_BR;
        if (b == 29) return K_J;
        if (b == 30) return K_JAL;
        return K_I;
    endfunction

    function automatic alu_op_t alu_of(input int b);
        case (b)
            2, 3, 25, 26: return ALU_SUB;
            4, 19:        return ALU_AND;
            5, 20:        return ALU_OR;
            6, 21:        return ALU_XOR;
            7:            return ALU_NOR;
            8, 27:        return ALU_SLT;
            9, 28:        return ALU_SLTU;
            10, 13:       return ALU_SLL;
            11, 14:       return ALU_SRL;
            12, 15:       return ALU_SRA;
            22:           return ALU_LUI;
            default:      return ALU_ADD;
        endcase
    endfunction

    function automatic logic [CODE_W-1:0] onehot(input int b);
        logic [CODE_W-1:0] c;
        c = '0;
        c[b] = 1'b1;
        return c;
    endfunction

    function automatic logic [CODE_W-1:0] rand_code();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[CODE_W-1:0];
    endfunction

    // Builds the expected phase sequence of one instruction and checks the DUT every cycle.
    task automatic run_instr(input string name, input logic [CODE_W-1:0] c, input int b, input bit bad,
                             input bit z, input int id, input int dd, input int abort_n);
        state_t     ph[$];
        kind_t      k;
        int         cnt;
        logic       e_pcwe, e_bsel;
        logic [1:0] e_pcsel, e_dst, e_wb;
        logic [5:0] e_strb;
        k = bad ? K_BAD : kind_of(b);
        for (int i = 0; i <= id; i++) ph.push_back(FETCH);
        ph.push_back(DECODE);
        if (k == K_BAD) begin
`ifdef ILLEGAL_TRAP_EN
            ph.push_back(TRAP);
`endif
        end else begin
            ph.push_back(EXEC);
            if (k == K_LW || k == K_SW) for (int i = 0; i <= dd; i++) ph.push_back(MEM);
            if (k == K_R || k == K_I || k == K_LW || k == K_JAL) ph.push_back(WB);
        end
        e_dst = (k == K_JAL) ? 2'd2 : (k == K_R) ? 2'd0 : 2'd1;
        e_wb  = (k == K_JAL) ? 2'd2 : (k == K_LW) ? 2'd1 : 2'd0;
        e_bsel = (k == K_I || k == K_LW || k == K_SW);
        cnt = 0;
        for (int n = 0; n < ph.size(); n++) begin
            if (n > 0 && ph[n] == ph[n-1]) cnt++; else cnt = 0;
            @(negedge clk);
            code     = (ph[n] == DECODE) ? c : rand_code();
            zero     = (ph[n] == EXEC) ? z : 1'($urandom);
            imem_ack = (ph[n] == FETCH) ? (cnt == id) : 1'($urandom);
            dmem_ack = (ph[n] == MEM) ? (cnt == dd) : 1'($urandom);
            #1;
            e_pcwe = 1'b0;
            e_pcsel = 2'd0;
            if (ph[n] == FETCH && cnt == id) e_pcwe = 1'b1;
            if (ph[n] == EXEC) begin
                case (k)
                    K_BR:    begin e_pcwe = (z == (b == 25)); e_pcsel = 2'd1; end
                    K_J:     begin e_pcwe = 1'b1; e_pcsel = 2'd2; end
                    K_JR:    begin e_pcwe = 1'b1; e_pcsel = 2'd3; end
                    default: ;
                endcase
            end
            if (ph[n] == WB && k == K_JAL) begin e_pcwe = 1'b1; e_pcsel = 2'd2; end
            e_strb = {ph[n] == FETCH, ph[n] == FETCH && cnt == id, ph[n] == DECODE,
                      ph[n] == MEM, ph[n] == WB, e_pcwe};
            if (ph[n] == TRAP) exp_halted = 1'b1;

            checks++;
            if (state !== ph[n]) begin
                failures++;
                $display("FAIL %s state cyc=%0d got=%0d expected=%0d", name, n, state, ph[n]);
            end
            checks++;
            if ({imem_req, ir_we, dec_ena, dmem_req, reg_we, pc_we} !== e_strb) begin
                failures++;
                $display("FAIL %s strobes{imem_req,ir_we,dec_ena,dmem_req,reg_we,pc_we} cyc=%0d got=%b expected=%b",
                         name, n, {imem_req, ir_we, dec_ena, dmem_req, reg_we, pc_we}, e_strb);
            end
            if (e_pcwe || (ph[n] == EXEC && k == K_BR)) begin
                checks++;
                if (pc_sel !== e_pcsel) begin
                    failures++;
                    $display("FAIL %s pc_sel cyc=%0d got=%0d expected=%0d", name, n, pc_sel, e_pcsel);
                end
            end
            if (ph[n] == MEM) begin
                checks++;
                if (dmem_we !== (k == K_SW)) begin
                    failures++;
                    $display("FAIL %s dmem_we cyc=%0d got=%b expected=%b", name, n, dmem_we, k == K_SW);
                end
            end
            if (ph[n] == WB) begin
                checks++;
                if ({reg_dst_sel, wb_sel} !== {e_dst, e_wb}) begin
                    failures++;
                    $display("FAIL %s wb_selects cyc=%0d got dst=%0d wb=%0d expected dst=%0d wb=%0d",
                             name, n, reg_dst_sel, wb_sel, e_dst, e_wb);
                end
            end
            if (ph[n] == EXEC) begin
                checks++;
                if ({alu_op, alu_b_sel} !== {alu_of(b), e_bsel}) begin
                    failures++;
                    $display("FAIL %s alu cyc=%0d got op=%0d bsel=%b expected op=%0d bsel=%b",
                             name, n, alu_op, alu_b_sel, alu_of(b), e_bsel);
                end
            end
            checks++;
            if (retired !== exp_retired || halted !== exp_halted) begin
                failures++;
                $display("FAIL %s retired_halted cyc=%0d got=%0d/%b expected=%0d/%b",
                         name, n, retired, halted, exp_retired, exp_halted);
            end
            if (n == abort_n) begin
                #2;
                rst_n    = 1'b0;
                imem_ack = 1'b0;
                dmem_ack = 1'b1;
                #1;
                exp_retired = '0;
                exp_halted  = 1'b0;
                checks++;
                if (dmem_req !== 1'b0 || imem_req !== 1'b0 || state !== FETCH || retired !== '0) begin
                    failures++;
                    $display("FAIL %s mid_reset got dmem_req=%b imem_req=%b state=%0d retired=%0d expected 0/0/%0d/0",
                             name, dmem_req, imem_req, state, retired, FETCH);
                end
                return;
            end
            if (n == ph.size() - 1) begin
`ifdef ILLEGAL_TRAP_EN
                if (k != K_BAD) exp_retired++;
`else
                exp_retired++;
`endif
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; code = '0; zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (state !== FETCH || retired !== '0 || halted !== 1'b0 ||
            {imem_req, ir_we, dec_ena, dmem_req, dmem_we, reg_we, pc_we} !== 7'b0 ||
            {reg_dst_sel, wb_sel, pc_sel} !== 6'b0) begin
            failures++;
            $display("FAIL reset_values got state=%0d retired=%0d halted=%b strobes=%b selects=%b expected all 0",
                     state, retired, halted, {imem_req, ir_we, dec_ena, dmem_req, dmem_we, reg_we, pc_we},
                     {reg_dst_sel, wb_sel, pc_sel});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (state !== FETCH || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_release got state=%0d imem_req=%b expected %0d/1", state, imem_req, FETCH);
        end
    endtask

    task automatic test_add();
        logic [RET_W-1:0] r0;
        r0 = exp_retired;
        run_instr("add", onehot(0), 0, 1'b0, 1'b0, 0, 0, -1);
        @(posedge clk); #1;
        checks++;
        if (retired !== r0 + 1 || state !== FETCH) begin
            failures++;
            $display("FAIL add_retire got retired=%0d state=%0d expected %0d/%0d", retired, state, r0 + 1, FETCH);
        end
    endtask

    task automatic test_lw_wait();
        logic [RET_W-1:0] r0;
        r0 = exp_retired;
        run_instr("lw_wait", onehot(23), 23, 1'b0, 1'b0, 0, 3, -1);
        @(posedge clk); #1;
        checks++;
        if (retired !== r0 + 1) begin
            failures++;
            $display("FAIL lw_retire got=%0d expected=%0d", retired, r0 + 1);
        end
    endtask

    task automatic test_beq();
        run_instr("beq_taken", onehot(25), 25, 1'b0, 1'b1, 0, 0, -1);
        run_instr("beq_not_taken", onehot(25), 25, 1'b0, 1'b0, 0, 0, -1);
        run_instr("bne_taken", onehot(26), 26, 1'b0, 1'b0, 1, 0, -1);
        run_instr("jr", onehot(16), 16, 1'b0, 1'b0, 0, 0, -1);
        run_instr("j", onehot(29), 29, 1'b0, 1'b1, 0, 0, -1);
    endtask

    task automatic test_jal();
        run_instr("jal", onehot(30), 30, 1'b0, 1'b0, 0, 0, -1);
        run_instr("sw", onehot(24), 24, 1'b0, 1'b0, 0, 0, -1);
    endtask

    task automatic test_back_to_back();
        int b;
        for (int i = 0; i < 40; i++) begin
            b = $urandom_range(0, 30);
            run_instr("random", onehot(b), b, 1'b0, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end
    endtask

    task automatic test_reset_mid_mem();
        run_instr("reset_in_mem", onehot(23), 23, 1'b0, 1'b0, 1, 6, 5);
        @(negedge clk);
        checks++;
        if (state !== FETCH || dmem_req !== 1'b0 || retired !== '0) begin
            failures++;
            $display("FAIL reset_hold got state=%0d dmem_req=%b retired=%0d expected %0d/0/0",
                     state, dmem_req, retired, FETCH);
        end
        rst_n = 1'b1; dmem_ack = 1'b0; imem_ack = 1'b0;
        run_instr("after_reset", onehot(5), 5, 1'b0, 1'b0, 0, 0, -1);
    endtask

    task automatic test_illegal();
        logic [RET_W-1:0] r0;
`ifdef ILLEGAL_TRAP_EN
        r0 = exp_retired;
        run_instr("illegal_trap", '0, 0, 1'b1, 1'b0, 0, 0, -1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            imem_ack = 1'b1;
            #1;
            checks++;
            if (state !== TRAP || imem_req !== 1'b0 || halted !== 1'b1 || retired !== r0) begin
                failures++;
                $display("FAIL trap_hold got state=%0d imem_req=%b halted=%b retired=%0d expected %0d/0/1/%0d",
                         state, imem_req, halted, retired, TRAP, r0);
            end
        end
`else
        logic [CODE_W-1:0] pats[4];
        pats[0] = '0;
        pats[1] = onehot(3) | onehot(20);
        pats[2] = onehot(0) | onehot(40);
        pats[3] = onehot(45);
        for (int i = 0; i < 4; i++) begin
            r0 = exp_retired;
            run_instr("illegal_nop", pats[i], 0, 1'b1, 1'b0, i % 2, 0, -1);
            @(posedge clk); #1;
            checks++;
            if (retired !== r0 + 1 || halted !== 1'b0 || state !== FETCH) begin
                failures++;
                $display("FAIL nop_retire pat=%0d got retired=%0d halted=%b state=%0d expected %0d/0/%0d",
                         i, retired, halted, state, r0 + 1, FETCH);
            end
        end
`endif
    endtask

    task automatic test_final_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || retired !== '0 || state !== FETCH || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL final_reset got halted=%b retired=%0d state=%0d imem_req=%b expected 0/0/%0d/0",
                     halted, retired, state, imem_req, FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_jal();
        test_back_to_back();
        test_reset_mid_mem();
        test_illegal();
        test_final_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
